// File: rtl/mem_writeback_stage_if.sv
// rtl/mem_writeback_stage_if.sv - upstream op, data-memory and register-file write bundle for mem_writeback_stage
// slave = the stage itself; master = the upstream/memory/register-file side.
interface mem_writeback_stage_if #(
  parameter int DW  = 16,
  parameter int RAW = 4
);
  logic           IN_VALID;
  logic           IN_READY;
  logic [DW-1:0]  ALUO;
  logic [DW-1:0]  STD;
  logic [RAW-1:0] DST;
  logic           MEMR;
  logic           MEMW;
  logic           REGW;
  logic [DW-1:0]  MA;
  logic [DW-1:0]  MWD;
  logic           MREQ;
  logic           MWE;
  logic           MACK;
  logic [DW-1:0]  MD;
  logic           RW;
  logic [RAW-1:0] WA;
  logic [DW-1:0]  RWD;
  logic           BUSY;
  logic           MERR;

  modport slave (
    input  IN_VALID, ALUO, STD, DST, MEMR, MEMW, REGW, MACK, MD,
    output IN_READY, MA, MWD, MREQ, MWE, RW, WA, RWD, BUSY, MERR
  );

  modport master (
    output IN_VALID, ALUO, STD, DST, MEMR, MEMW, REGW, MACK, MD,
    input  IN_READY, MA, MWD, MREQ, MWE, RW, WA, RWD, BUSY, MERR
  );
endinterface

// File: rtl/mem_writeback_stage.sv
// rtl/mem_writeback_stage.sv - memory access and register writeback stage (IDLE/MEM/WB)
// Optional memory-wait abort enabled by defining MEM_TIMEOUT_EN.
module mem_writeback_stage #(
  parameter int DW      = 16,
  parameter int RAW     = 4
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  mem_writeback_stage_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_WB} state_t;

  state_t         r_state;
  logic           r_in_ready;
  logic           r_busy;
  logic [DW-1:0]  r_ma;
  logic [DW-1:0]  r_mwd;
  logic           r_mreq;
  logic [RAW-1:0] r_dst;
  logic           r_memr;
  logic           r_memw;
  logic           r_regw;
  logic           r_rw;
  logic [RAW-1:0] r_wa;
  logic [DW-1:0]  r_rwd;

  logic w_accept;
  logic w_mem_op;
  logic w_load;

  assign w_accept = bus.IN_VALID && r_in_ready;
  assign w_mem_op = bus.MEMR || bus.MEMW;
  // Store wins when both MEMR and MEMW are set.
  assign w_load   = r_memr && !r_memw;

`ifdef MEM_TIMEOUT_EN
  localparam logic [DW-1:0] TMO_LAST = DW'(TIMEOUT - 1);
  logic [DW-1:0] r_cnt;
  logic          r_merr;
  assign bus.MERR = r_merr;
`else
  assign bus.MERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_ma       <= '0;
      r_mwd      <= '0;
      r_mreq     <= 1'b0;
      r_dst      <= '0;
      r_memr     <= 1'b0;
      r_memw     <= 1'b0;
      r_regw     <= 1'b0;
      r_rw       <= 1'b0;
      r_wa       <= '0;
      r_rwd      <= '0;
`ifdef MEM_TIMEOUT_EN
      r_cnt      <= '0;
      r_merr     <= 1'b0;
`endif
    end else begin
      r_rw <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_merr <= 1'b0;
`endif
      case (r_state)
        S_MEM: begin
          if (bus.MACK) begin
            r_mreq     <= 1'b0;
            r_in_ready <= 1'b1;
            if (w_load && r_regw) begin
              r_state <= S_WB;
              r_busy  <= 1'b1;
              r_rw    <= 1'b1;
              r_wa    <= r_dst;
              r_rwd   <= bus.MD;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_cnt == TMO_LAST) begin
            r_mreq     <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_merr     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: begin
          // IDLE and WB both accept; WB falls back to IDLE when nothing arrives.
          if (w_accept) begin
            r_ma   <= bus.ALUO;
            r_mwd  <= bus.STD;
            r_dst  <= bus.DST;
            r_memr <= bus.MEMR;
            r_memw <= bus.MEMW;
            r_regw <= bus.REGW;
            if (w_mem_op) begin
              r_state    <= S_MEM;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b0;
              r_mreq     <= 1'b1;
`ifdef MEM_TIMEOUT_EN
              r_cnt      <= '0;
`endif
            end else if (bus.REGW) begin
              r_state    <= S_WB;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b1;
              r_rw       <= 1'b1;
              r_wa       <= bus.DST;
              r_rwd      <= bus.ALUO;
            end else begin
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b1;
            end
          end else begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.IN_READY = r_in_ready;
  assign bus.BUSY     = r_busy;
  assign bus.MA       = r_ma;
  assign bus.MWD      = r_mwd;
  assign bus.MREQ     = r_mreq;
  assign bus.MWE      = r_memw;
  assign bus.RW       = r_rw;
  assign bus.WA       = r_wa;
  assign bus.RWD      = r_rwd;

endmodule

// File: tb/tb_mem_writeback_stage.sv
// tb/tb_mem_writeback_stage.sv - directed self-checking bench for mem_writeback_stage
// Define MEM_TIMEOUT_EN on both RTL and bench to add the timeout scenario.
module tb_mem_writeback_stage;

  logic CLK;
  logic RESET_N;
  int   n_cmp;
  int   n_err;

  mem_writeback_stage_if #(.DW(16), .RAW(4)) bus ();

  mem_writeback_stage #(
    .DW(16),
    .RAW(4)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT(4)
`endif
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [15:0] aluo, input logic [15:0] std,
                        input logic [3:0] dst, input logic memr, input logic memw, input logic regw);
    bus.IN_VALID = v;
    bus.ALUO     = aluo;
    bus.STD      = std;
    bus.DST      = dst;
    bus.MEMR     = memr;
    bus.MEMW     = memw;
    bus.REGW     = regw;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RESET_N  = 1'b0;
    bus.MACK = 1'b0;
    bus.MD   = '0;
    set_op(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_in_ready", bus.IN_READY, 1);
    chk("rst_mreq",     bus.MREQ, 0);
    chk("rst_mwe",      bus.MWE, 0);
    chk("rst_rw",       bus.RW, 0);
    chk("rst_busy",     bus.BUSY, 0);
    chk("rst_merr",     bus.MERR, 0);
    chk("rst_wa",       bus.WA, 0);
    chk("rst_rwd",      bus.RWD, 0);
    chk("rst_ma",       bus.MA, 0);
    chk("rst_mwd",      bus.MWD, 0);
    RESET_N = 1'b1;
    tick();

    // ALU op
    set_op(1'b1, 16'h0002, 16'h0, 4'd1, 1'b0, 1'b0, 1'b1);
    tick();
    set_op(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("alu_rw",   bus.RW, 1);
    chk("alu_wa",   bus.WA, 1);
    chk("alu_rwd",  bus.RWD, 16'h0002);
    chk("alu_mreq", bus.MREQ, 0);
    chk("alu_busy", bus.BUSY, 1);
    tick();
    chk("alu_rw_off",  bus.RW, 0);
    chk("alu_wa_hold", bus.WA, 1);
    chk("alu_rwd_hold", bus.RWD, 16'h0002);
    chk("alu_idle",    bus.BUSY, 0);

    // Load with ack in the third MEM cycle
    set_op(1'b1, 16'h0010, 16'h0, 4'd0, 1'b1, 1'b0, 1'b1);
    tick();
    set_op(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("ld_mreq1", bus.MREQ, 1);
    chk("ld_mwe",   bus.MWE, 0);
    chk("ld_ma",    bus.MA, 16'h0010);
    chk("ld_rdy",   bus.IN_READY, 0);
    tick();
    chk("ld_mreq2", bus.MREQ, 1);
    chk("ld_rw_wait", bus.RW, 0);
    tick();
    chk("ld_mreq3", bus.MREQ, 1);
    bus.MACK = 1'b1;
    bus.MD   = 16'h0008;
    tick();
    bus.MACK = 1'b0;
    bus.MD   = 16'h0;
    chk("ld_rw",    bus.RW, 1);
    chk("ld_wa",    bus.WA, 0);
    chk("ld_rwd",   bus.RWD, 16'h0008);
    chk("ld_mreq_off", bus.MREQ, 0);
    chk("ld_rdy_wb", bus.IN_READY, 1);
    tick();
    chk("ld_rw_off", bus.RW, 0);

    // Stray MACK while idle
    bus.MACK = 1'b1;
    tick();
    bus.MACK = 1'b0;
    chk("stray_mreq", bus.MREQ, 0);
    chk("stray_busy", bus.BUSY, 0);
    chk("stray_rw",   bus.RW, 0);

    // Store with same-cycle ack
    set_op(1'b1, 16'h0020, 16'h0004, 4'd7, 1'b0, 1'b1, 1'b1);
    tick();
    set_op(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("st_mreq", bus.MREQ, 1);
    chk("st_mwe",  bus.MWE, 1);
    chk("st_ma",   bus.MA, 16'h0020);
    chk("st_mwd",  bus.MWD, 16'h0004);
    bus.MACK = 1'b1;
    tick();
    bus.MACK = 1'b0;
    chk("st_mreq_off", bus.MREQ, 0);
    chk("st_rw",   bus.RW, 0);
    chk("st_busy", bus.BUSY, 0);
    tick();
    chk("st_rw_late", bus.RW, 0);

    // Back-to-back ALU ops
    set_op(1'b1, 16'h0001, 16'h0, 4'd2, 1'b0, 1'b0, 1'b1);
    tick();
    chk("b2b_rw0",  bus.RW, 1);
    chk("b2b_wa0",  bus.WA, 2);
    chk("b2b_rwd0", bus.RWD, 16'h0001);
    chk("b2b_rdy0", bus.IN_READY, 1);
    set_op(1'b1, 16'h0002, 16'h0, 4'd3, 1'b0, 1'b0, 1'b1);
    tick();
    chk("b2b_rw1",  bus.RW, 1);
    chk("b2b_wa1",  bus.WA, 3);
    chk("b2b_rwd1", bus.RWD, 16'h0002);
    set_op(1'b1, 16'h0003, 16'h0, 4'd4, 1'b0, 1'b0, 1'b1);
    tick();
    chk("b2b_rw2",  bus.RW, 1);
    chk("b2b_wa2",  bus.WA, 4);
    chk("b2b_rwd2", bus.RWD, 16'h0003);
    set_op(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("b2b_rw_off", bus.RW, 0);
    chk("b2b_busy",   bus.BUSY, 0);

    // MEMR and MEMW together behave as a store without writeback
    set_op(1'b1, 16'h0030, 16'h0055, 4'd9, 1'b1, 1'b1, 1'b1);
    tick();
    set_op(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("both_mwe", bus.MWE, 1);
    chk("both_mwd", bus.MWD, 16'h0055);
    bus.MACK = 1'b1;
    bus.MD   = 16'hBEEF;
    tick();
    bus.MACK = 1'b0;
    chk("both_rw",   bus.RW, 0);
    chk("both_wa",   bus.WA, 4);
    chk("both_rwd",  bus.RWD, 16'h0003);
    chk("both_busy", bus.BUSY, 0);

    // No-op is consumed without effect
    set_op(1'b1, 16'h0099, 16'h0, 4'd8, 1'b0, 1'b0, 1'b0);
    tick();
    set_op(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("nop_rw",   bus.RW, 0);
    chk("nop_busy", bus.BUSY, 0);
    chk("nop_rdy",  bus.IN_READY, 1);
    chk("nop_mreq", bus.MREQ, 0);

    // Asynchronous reset during a memory wait
    set_op(1'b1, 16'h0040, 16'h0, 4'd5, 1'b1, 1'b0, 1'b1);
    tick();
    set_op(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("ar_mreq_before", bus.MREQ, 1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("ar_mreq_now", bus.MREQ, 0);
    chk("ar_rdy_now",  bus.IN_READY, 1);
    chk("ar_busy_now", bus.BUSY, 0);
    tick();
    RESET_N = 1'b1;
    tick();
    chk("ar_rw",  bus.RW, 0);
    chk("ar_rdy", bus.IN_READY, 1);
    set_op(1'b1, 16'h0077, 16'h0, 4'd6, 1'b0, 1'b0, 1'b1);
    tick();
    set_op(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("ar_alu_rw",  bus.RW, 1);
    chk("ar_alu_wa",  bus.WA, 6);
    chk("ar_alu_rwd", bus.RWD, 16'h0077);
    tick();
    chk("ar_alu_off", bus.RW, 0);

`ifdef MEM_TIMEOUT_EN
    // Load never acknowledged: aborts after TIMEOUT=4 MEM cycles
    set_op(1'b1, 16'h0050, 16'h0, 4'd3, 1'b1, 1'b0, 1'b1);
    tick();
    set_op(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("to_mreq1", bus.MREQ, 1);
    tick();
    chk("to_mreq2", bus.MREQ, 1);
    tick();
    chk("to_mreq3", bus.MREQ, 1);
    tick();
    chk("to_mreq4", bus.MREQ, 1);
    chk("to_merr_early", bus.MERR, 0);
    tick();
    chk("to_mreq_off", bus.MREQ, 0);
    chk("to_merr",     bus.MERR, 1);
    chk("to_rw",       bus.RW, 0);
    chk("to_busy",     bus.BUSY, 0);
    tick();
    chk("to_merr_off", bus.MERR, 0);
    chk("to_rw_late",  bus.RW, 0);
`else
    // Without the timeout the stage waits indefinitely and MERR stays low
    set_op(1'b1, 16'h0050, 16'h0, 4'd3, 1'b1, 1'b0, 1'b1);
    tick();
    set_op(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) tick();
    chk("wait_mreq", bus.MREQ, 1);
    chk("wait_merr", bus.MERR, 0);
    chk("wait_busy", bus.BUSY, 1);
    bus.MACK = 1'b1;
    bus.MD   = 16'h1234;
    tick();
    bus.MACK = 1'b0;
    chk("wait_rw",  bus.RW, 1);
    chk("wait_wa",  bus.WA, 3);
    chk("wait_rwd", bus.RWD, 16'h1234);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
